// File: rtl/usart_pkg.sv
// usart_pkg
//   Shared definitions for the USART transmit path: default byte width and
//   the state encoding of the transmit arbiter.
package usart_pkg;

  localparam int USART_DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_START     = 3'd2,
    ST_WAIT_BUSY = 3'd3,
    ST_WAIT_DONE = 3'd4
  } usart_arb_state_e;

endpackage

// File: rtl/usart_rr_picker.sv
// usart_rr_picker
//   Combinational two-way round-robin pick. With a single requester valid
//   it simply picks that one. With both valid it picks the one that did
//   not win last time.
// Ports:
//   valid_i        requester valid bits, bit 0 = requester 0
//   last_winner_i  index of the requester that owned the previous packet
//   pick_o         one-hot pick, 00 when nothing is valid
module usart_rr_picker (
  input  logic [1:0] valid_i,
  input  logic       last_winner_i,
  output logic [1:0] pick_o
);

  always_comb begin
    pick_o = valid_i;
    if (valid_i == 2'b11) begin
      pick_o = last_winner_i ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/usart_tx_arbiter.sv
// usart_tx_arbiter
//   Shares one USART tx engine between two byte-stream requesters. The
//   engine is granted round-robin per packet. A packet is a run of bytes
//   that ends with a byte flagged last. The owner keeps the engine until
//   its last byte has gone out, or until it leaves valid low in LOAD for
//   LOCK_TIMEOUT cycles.
// Ports:
//   clock, reset             system clock, synchronous active-high reset
//   reqN_valid/data/last     requester N byte stream
//   reqN_ready               byte accepted this cycle (LOAD state only)
//   tx_start                 one-cycle start pulse to the tx engine
//   tx_data                  byte being transmitted, held until the next capture
//   tx_busy                  engine is shifting a frame
//   grant                    one-hot current owner, 00 when idle
//   lock_timeout             one-cycle pulse when a lock is force-released
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE       | no owner; grant once the engine is free and a valid is high
// LOAD       | owner may hand over a byte; the lock timer runs while it is absent
// START      | tx_start pulse for the captured byte
// WAIT_BUSY  | waiting for the engine to acknowledge with busy
// WAIT_DONE  | waiting for the frame to finish; release or fetch the next byte
module usart_tx_arbiter
  import usart_pkg::*;
#(
  parameter int DATA_W       = USART_DATA_W,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req0_last,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              req1_last,
  output logic              req1_ready,
  output logic              tx_start,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_busy,
  output logic [1:0]        grant,
  output logic              lock_timeout
);

  localparam int TO_W = $clog2(LOCK_TIMEOUT + 1);

  usart_arb_state_e  state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              last_winner_q, last_winner_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic              cap_last_q, cap_last_d;

  logic [1:0]        valid_vec;
  logic [1:0]        pick;
  logic              owner_valid;
  logic [DATA_W-1:0] owner_data;
  logic              owner_last;

  assign valid_vec   = {req1_valid, req0_valid};
  assign owner_valid = |(grant_q & valid_vec);
  assign owner_data  = grant_q[1] ? req1_data : req0_data;
  assign owner_last  = grant_q[1] ? req1_last : req0_last;

  usart_rr_picker u_picker (
    .valid_i       (valid_vec),
    .last_winner_i (last_winner_q),
    .pick_o        (pick)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      grant_q       <= 2'b00;
      tx_data_q     <= '0;
      last_winner_q <= 1'b1;
      cnt_q         <= '0;
      cap_last_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      tx_data_q     <= tx_data_d;
      last_winner_q <= last_winner_d;
      cnt_q         <= cnt_d;
      cap_last_q    <= cap_last_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    tx_data_d     = tx_data_q;
    last_winner_d = last_winner_q;
    cnt_d         = cnt_q;
    cap_last_d    = cap_last_q;
    req0_ready    = 1'b0;
    req1_ready    = 1'b0;
    tx_start      = 1'b0;
    lock_timeout  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // The engine may still be finishing a frame started before a reset.
        if (!tx_busy && (|valid_vec)) begin
          grant_d = pick;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        req0_ready = grant_q[0] & req0_valid;
        req1_ready = grant_q[1] & req1_valid;
        if (owner_valid) begin
          tx_data_d  = owner_data;
          cap_last_d = owner_last;
          cnt_d      = '0;
          state_d    = ST_START;
        end else if (cnt_q == TO_W'(LOCK_TIMEOUT - 1)) begin
          lock_timeout  = 1'b1;
          last_winner_d = grant_q[1];
          grant_d       = 2'b00;
          cnt_d         = '0;
          state_d       = ST_IDLE;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      ST_START: begin
        tx_start = 1'b1;
        state_d  = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) begin
          if (cap_last_q) begin
            last_winner_d = grant_q[1];
            grant_d       = 2'b00;
            state_d       = ST_IDLE;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  assign grant   = grant_q;
  assign tx_data = tx_data_q;

endmodule
